// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stage controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_WAIT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_HALT    = 2'd3
  } pipe_state_e;

  // Bit positions of each pipeline latch inside the internal ena/x vectors.
  localparam int unsigned NUM_STG = 4;
  localparam logic [1:0] STG_IFID  = 2'd0;
  localparam logic [1:0] STG_IDEX  = 2'd1;
  localparam logic [1:0] STG_EXMEM = 2'd2;
  localparam logic [1:0] STG_MEMWB = 2'd3;

endpackage : pipe_ctrl_pkg

// File: rtl/hazard_unit.sv
// Load-use hazard detection: the instruction in ID needs a register that a
// load in EX has not produced yet. Register 0 is hard-wired and never stalls.
module hazard_unit #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  output logic             load_use_stall
);

  logic rs1_hit;
  logic rs2_hit;

  // Source-operand match against the pending load destination.
  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);

  // Stall only for a real (non-zero) load destination.
  assign load_use_stall = ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule : hazard_unit

// File: rtl/pipe_stage_ctrl.sv
// Pipeline latch sequencer: drives the ena/x pair of every pipeline latch and
// the PC enable, handling load-use stalls, branch flushes, multi-cycle EX ops
// and halt/drain.
//
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   ST_RUN     | normal flow; branch > multi-cycle start > load-use > halt
//   ST_MC_WAIT | front end and EX held waiting for mc_done (or timeout)
//   ST_DRAIN   | fetch suppressed, bubbles into IF/ID while the back end empties
//   ST_HALT    | every latch frozen, halted asserted until halt_req drops
module pipe_stage_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W        = 5,
  parameter int DRAIN_CYCLES = 4,
  parameter int MC_MAX       = 64,
  parameter int CNT_W        = 32
) (
  input  logic             stg_clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  input  logic             ex_mc_start,
  input  logic             mc_done,
  input  logic             halt_req,
  output logic             pc_ena,
  output logic             ifid_ena,
  output logic             ifid_x,
  output logic             idex_ena,
  output logic             idex_x,
  output logic             exmem_ena,
  output logic             exmem_x,
  output logic             memwb_ena,
  output logic             memwb_x,
  output logic             halted,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MC_CW = $clog2(MC_MAX + 1);
  localparam int DR_CW = $clog2(DRAIN_CYCLES + 1);

  pipe_state_e        state;
  pipe_state_e        next_state;
  logic [MC_CW-1:0]   mc_cnt;
  logic [DR_CW-1:0]   drain_cnt;
  logic [NUM_STG-1:0] ena_v;
  logic [NUM_STG-1:0] x_v;
  logic               load_use_stall;
  logic               mc_hit_max;
  logic               drain_last;

  hazard_unit #(
    .REG_W (REG_W)
  ) u_hazard (
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_rd          (ex_rd),
    .ex_is_load     (ex_is_load),
    .load_use_stall (load_use_stall)
  );

  assign mc_hit_max = (mc_cnt == MC_CW'(MC_MAX));
  assign drain_last = (drain_cnt == DR_CW'(DRAIN_CYCLES - 1));

  // State register.
  always_ff @(posedge stg_clk or negedge reset) begin
    if (!reset) state <= ST_RUN;
    else        state <= next_state;
  end

  // Next-state decode; halt_req is only honoured from RUN, so MC_WAIT defers it.
  always_comb begin
    next_state = state;
    case (state)
      ST_RUN: begin
        if (ex_br_taken)         next_state = ST_RUN;
        else if (ex_mc_start)    next_state = ST_MC_WAIT;
        else if (load_use_stall) next_state = ST_RUN;
        else if (halt_req)       next_state = ST_DRAIN;
      end
      ST_MC_WAIT: begin
        if (mc_done || mc_hit_max) next_state = ST_RUN;
      end
      ST_DRAIN: begin
        if (!halt_req)       next_state = ST_RUN;
        else if (drain_last) next_state = ST_HALT;
      end
      ST_HALT: begin
        if (!halt_req) next_state = ST_RUN;
      end
      default: next_state = ST_RUN;
    endcase
  end

  // Latch/PC control decode; reset forces every latch to hold a bubble.
  always_comb begin
    ena_v  = '1;
    x_v    = '0;
    pc_ena = 1'b1;
    if (!reset) begin
      ena_v  = '0;
      x_v    = '1;
      pc_ena = 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (ex_br_taken) begin
            x_v[STG_IFID] = 1'b1;
            x_v[STG_IDEX] = 1'b1;
          end else if (ex_mc_start) begin
            pc_ena          = 1'b0;
            ena_v[STG_IFID] = 1'b0;
            ena_v[STG_IDEX] = 1'b0;
            x_v[STG_EXMEM]  = 1'b1;
          end else if (load_use_stall) begin
            pc_ena          = 1'b0;
            ena_v[STG_IFID] = 1'b0;
            x_v[STG_IDEX]   = 1'b1;
          end
        end
        ST_MC_WAIT: begin
          // On timeout the op leaves EX with no result: bubble into EX/MEM.
          if (!mc_done) begin
            x_v[STG_EXMEM] = 1'b1;
            if (!mc_hit_max) begin
              pc_ena          = 1'b0;
              ena_v[STG_IFID] = 1'b0;
              ena_v[STG_IDEX] = 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          pc_ena        = 1'b0;
          x_v[STG_IFID] = 1'b1;
        end
        ST_HALT: begin
          pc_ena = 1'b0;
          ena_v  = '0;
        end
        default: begin
          pc_ena = 1'b0;
          ena_v  = '0;
        end
      endcase
    end
  end

  assign ifid_ena  = ena_v[STG_IFID];
  assign ifid_x    = x_v[STG_IFID];
  assign idex_ena  = ena_v[STG_IDEX];
  assign idex_x    = x_v[STG_IDEX];
  assign exmem_ena = ena_v[STG_EXMEM];
  assign exmem_x   = x_v[STG_EXMEM];
  assign memwb_ena = ena_v[STG_MEMWB];
  assign memwb_x   = x_v[STG_MEMWB];

  // Multi-cycle wait counter: 1 on the first MC_WAIT cycle, cleared elsewhere.
  always_ff @(posedge stg_clk or negedge reset) begin
    if (!reset)                        mc_cnt <= '0;
    else if (next_state == ST_MC_WAIT) mc_cnt <= (state == ST_MC_WAIT) ? mc_cnt + MC_CW'(1) : MC_CW'(1);
    else                               mc_cnt <= '0;
  end

  // Drain counter: 0 on the first DRAIN cycle.
  always_ff @(posedge stg_clk or negedge reset) begin
    if (!reset)                                             drain_cnt <= '0;
    else if (state == ST_DRAIN && next_state == ST_DRAIN)   drain_cnt <= drain_cnt + DR_CW'(1);
    else                                                    drain_cnt <= '0;
  end

  // Registered status flags, aligned with the state they describe.
  always_ff @(posedge stg_clk or negedge reset) begin
    if (!reset) begin
      halted     <= 1'b0;
      mc_timeout <= 1'b0;
    end else begin
      halted     <= (next_state == ST_HALT);
      mc_timeout <= (state == ST_MC_WAIT) && !mc_done && mc_hit_max;
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge stg_clk or negedge reset) begin
    if (!reset)                          stall_cnt <= '0;
    else if (!pc_ena && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule : pipe_stage_ctrl

// File: tb/tb_pipe_stage_ctrl.sv
// Self-checking bench for pipe_stage_ctrl. Expected latch/PC controls are
// queued as each cycle's stimulus is applied and compared by the monitor.
module tb_pipe_stage_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  // {pc_ena, ifid_ena, ifid_x, idex_ena, idex_x, exmem_ena, exmem_x, memwb_ena, memwb_x}
  localparam logic [8:0] O_RUN   = 9'b1_10_10_10_10;
  localparam logic [8:0] O_BR    = 9'b1_11_11_10_10;
  localparam logic [8:0] O_LU    = 9'b0_00_11_10_10;
  localparam logic [8:0] O_MC    = 9'b0_00_00_11_10;
  localparam logic [8:0] O_TO    = 9'b1_10_10_11_10;
  localparam logic [8:0] O_DRAIN = 9'b0_11_10_10_10;
  localparam logic [8:0] O_HALT  = 9'b0_00_00_00_00;
  localparam logic [8:0] O_RST   = 9'b0_01_01_01_01;

  logic             stg_clk = 1'b0;
  logic             reset;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_is_load, ex_br_taken;
  logic             ex_mc_start, mc_done, halt_req;
  logic             pc_ena, ifid_ena, ifid_x, idex_ena, idex_x;
  logic             exmem_ena, exmem_x, memwb_ena, memwb_x;
  logic             halted, mc_timeout;
  logic [CNT_W-1:0] stall_cnt;

  typedef struct {
    logic [8:0] outs;
    string      tag;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [8:0] mon_act;
  int         checks = 0;
  int         errors = 0;

  always #5 stg_clk = ~stg_clk;

  pipe_stage_ctrl #(
    .REG_W(REG_W), .DRAIN_CYCLES(4), .MC_MAX(64), .CNT_W(CNT_W)
  ) dut (
    .stg_clk(stg_clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .ex_mc_start(ex_mc_start), .mc_done(mc_done), .halt_req(halt_req),
    .pc_ena(pc_ena), .ifid_ena(ifid_ena), .ifid_x(ifid_x), .idex_ena(idex_ena), .idex_x(idex_x),
    .exmem_ena(exmem_ena), .exmem_x(exmem_x), .memwb_ena(memwb_ena), .memwb_x(memwb_x),
    .halted(halted), .mc_timeout(mc_timeout), .stall_cnt(stall_cnt)
  );

  // Scoreboard consumer: combinational controls are sampled mid low-phase.
  always @(negedge stg_clk) begin
    #2;
    if (sb_q.size() > 0) begin
      mon_e   = sb_q.pop_front();
      mon_act = {pc_ena, ifid_ena, ifid_x, idex_ena, idex_x, exmem_ena, exmem_x, memwb_ena, memwb_x};
      checks++;
      if (mon_act !== mon_e.outs) begin
        errors++;
        $display("FAIL %s: controls got %b expected %b", mon_e.tag, mon_act, mon_e.outs);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [8:0] o, input string tag);
    exp_t e;
    e.outs = o;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_is_load = 0; ex_br_taken = 0;
    ex_mc_start = 0; mc_done = 0; halt_req = 0;
  endtask

  task automatic test_reset();
    @(negedge stg_clk);
    idle_inputs();
    ex_br_taken = 1; ex_mc_start = 1;
    push_exp(O_RST, "reset_forced");
    checks++;
    if (stall_cnt !== '0 || halted !== 1'b0 || mc_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: stall=%0d halted=%b to=%b expected 0/0/0", stall_cnt, halted, mc_timeout);
    end
    @(negedge stg_clk);
    reset = 1; idle_inputs();
    push_exp(O_RUN, "reset_release");
    @(negedge stg_clk);
    push_exp(O_RUN, "run_idle");
    checks++;
    if (stall_cnt !== 0) begin
      errors++;
      $display("FAIL reset_stall: stall_cnt %0d expected 0", stall_cnt);
    end
  endtask

  task automatic test_load_use();
    @(negedge stg_clk); idle_inputs();
    ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    push_exp(O_LU, "lu_rs1");
    @(negedge stg_clk); idle_inputs();
    push_exp(O_RUN, "lu_one_bubble");
    checks++;
    if (stall_cnt !== 1) begin errors++; $display("FAIL lu_stall1: stall_cnt %0d expected 1", stall_cnt); end
    @(negedge stg_clk); idle_inputs();
    ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    push_exp(O_RUN, "lu_rd_zero");
    @(negedge stg_clk); idle_inputs();
    ex_is_load = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
    push_exp(O_LU, "lu_rs2");
    checks++;
    if (stall_cnt !== 1) begin errors++; $display("FAIL lu_rd0_nostall: stall_cnt %0d expected 1", stall_cnt); end
    @(negedge stg_clk); idle_inputs();
    ex_is_load = 1; ex_rd = 7; id_rs2 = 7; id_rs1 = 7;
    push_exp(O_RUN, "lu_no_use");
    checks++;
    if (stall_cnt !== 2) begin errors++; $display("FAIL lu_stall2: stall_cnt %0d expected 2", stall_cnt); end
    @(negedge stg_clk); idle_inputs();
    ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
    push_exp(O_RUN, "lu_not_load");
  endtask

  task automatic test_branch();
    @(negedge stg_clk); idle_inputs();
    ex_br_taken = 1; ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    push_exp(O_BR, "br_over_lu");
    @(negedge stg_clk); idle_inputs();
    push_exp(O_RUN, "br_after");
    checks++;
    if (stall_cnt !== 2) begin errors++; $display("FAIL br_stall: stall_cnt %0d expected 2", stall_cnt); end
    @(negedge stg_clk); idle_inputs();
    ex_br_taken = 1; ex_mc_start = 1;
    push_exp(O_BR, "br_over_mc");
    @(negedge stg_clk); idle_inputs();
    push_exp(O_RUN, "br_mc_ignored");
    @(negedge stg_clk); idle_inputs();
    ex_br_taken = 1; halt_req = 1;
    push_exp(O_BR, "br_over_halt");
    @(negedge stg_clk); idle_inputs();
    push_exp(O_RUN, "br_halt_ignored");
  endtask

  task automatic test_mc_done();
    @(negedge stg_clk); idle_inputs();
    ex_mc_start = 1; ex_is_load = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
    push_exp(O_MC, "mc_start");
    for (int i = 1; i <= 3; i++) begin
      @(negedge stg_clk); idle_inputs();
      ex_mc_start = 1;
      push_exp(O_MC, $sformatf("mc_wait%0d", i));
    end
    @(negedge stg_clk); idle_inputs();
    ex_mc_start = 1; mc_done = 1;
    push_exp(O_RUN, "mc_done");
    @(negedge stg_clk); idle_inputs();
    push_exp(O_RUN, "mc_back_run");
    checks++;
    if (stall_cnt !== 6) begin errors++; $display("FAIL mc_stall: stall_cnt %0d expected 6", stall_cnt); end
    @(negedge stg_clk); idle_inputs();
    mc_done = 1;
    push_exp(O_RUN, "mc_done_in_run");
    @(negedge stg_clk); idle_inputs();
    push_exp(O_RUN, "mc_done_ignored");
  endtask

  task automatic test_mc_timeout();
    @(negedge stg_clk); idle_inputs();
    ex_mc_start = 1;
    push_exp(O_MC, "to_start");
    for (int k = 1; k <= 63; k++) begin
      @(negedge stg_clk); idle_inputs();
      ex_mc_start = 1;
      push_exp(O_MC, $sformatf("to_wait%0d", k));
    end
    @(negedge stg_clk); idle_inputs();
    ex_mc_start = 1;
    push_exp(O_TO, "to_cycle64");
    checks++;
    if (mc_timeout !== 1'b0) begin errors++; $display("FAIL to_early: mc_timeout %b expected 0", mc_timeout); end
    @(negedge stg_clk); idle_inputs();
    push_exp(O_RUN, "to_run_next");
    checks++;
    if (mc_timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: mc_timeout %b expected 1", mc_timeout); end
    checks++;
    if (stall_cnt !== 70) begin errors++; $display("FAIL to_stall: stall_cnt %0d expected 70", stall_cnt); end
    @(negedge stg_clk); idle_inputs();
    push_exp(O_RUN, "to_after");
    checks++;
    if (mc_timeout !== 1'b0) begin errors++; $display("FAIL to_width: mc_timeout %b expected 0", mc_timeout); end
  endtask

  task automatic test_halt();
    @(negedge stg_clk); idle_inputs(); halt_req = 1;
    push_exp(O_RUN, "halt_req_run");
    for (int i = 1; i <= 4; i++) begin
      @(negedge stg_clk); idle_inputs(); halt_req = 1;
      push_exp(O_DRAIN, $sformatf("drain%0d", i));
    end
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL drain_halted: halted %b expected 0", halted); end
    @(negedge stg_clk); idle_inputs(); halt_req = 1;
    push_exp(O_HALT, "halt1");
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: halted %b expected 1", halted); end
    @(negedge stg_clk); idle_inputs(); halt_req = 1;
    push_exp(O_HALT, "halt2");
    @(negedge stg_clk); idle_inputs();
    push_exp(O_HALT, "halt_drop");
    @(negedge stg_clk); idle_inputs();
    push_exp(O_RUN, "halt_resume");
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear: halted %b expected 0", halted); end
    checks++;
    if (stall_cnt !== 77) begin errors++; $display("FAIL halt_stall: stall_cnt %0d expected 77", stall_cnt); end
    @(negedge stg_clk); idle_inputs(); halt_req = 1;
    push_exp(O_RUN, "abort_req");
    @(negedge stg_clk); idle_inputs(); halt_req = 1;
    push_exp(O_DRAIN, "abort_drain");
    @(negedge stg_clk); idle_inputs();
    push_exp(O_DRAIN, "abort_drop");
    @(negedge stg_clk); idle_inputs();
    push_exp(O_RUN, "abort_run");
    checks++;
    if (stall_cnt !== 79 || halted !== 1'b0) begin
      errors++;
      $display("FAIL abort_regs: stall_cnt %0d halted %b expected 79/0", stall_cnt, halted);
    end
  endtask

  task automatic test_reset_mid_mc();
    @(negedge stg_clk); idle_inputs(); ex_mc_start = 1;
    push_exp(O_MC, "rm_start");
    @(negedge stg_clk); idle_inputs(); ex_mc_start = 1;
    push_exp(O_MC, "rm_wait");
    @(negedge stg_clk); idle_inputs(); ex_mc_start = 1;
    reset = 0;
    push_exp(O_RST, "rm_reset");
    #1;
    checks++;
    if (stall_cnt !== 0 || mc_timeout !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL rm_regs: stall=%0d to=%b halted=%b expected 0/0/0", stall_cnt, mc_timeout, halted);
    end
    @(negedge stg_clk); idle_inputs(); reset = 1;
    push_exp(O_RUN, "rm_release");
    @(negedge stg_clk); idle_inputs(); mc_done = 1;
    push_exp(O_RUN, "rm_stale_done");
    @(negedge stg_clk); idle_inputs();
    push_exp(O_RUN, "rm_run");
    checks++;
    if (stall_cnt !== 0) begin errors++; $display("FAIL rm_stall: stall_cnt %0d expected 0", stall_cnt); end
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    test_reset();
    test_load_use();
    test_branch();
    test_mc_done();
    test_mc_timeout();
    test_halt();
    test_reset_mid_mc();
    @(negedge stg_clk);
    #4;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pipe_stage_ctrl
